// File: rtl/div_clip_pkg.sv
// Shared definitions for the saturating fixed-point divider: FSM encoding,
// saturation constants and derived widths.
package div_clip_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    // Left shift that aligns the dividend so the integer quotient lands on BIN_PT_O.
    function automatic int shift_amt(input int bin_pt_n, input int bin_pt_d, input int bin_pt_o);
        return bin_pt_o - bin_pt_n + bin_pt_d;
    endfunction

    function automatic int cnt_width(input int width_o);
        return $clog2(width_o + 1);
    endfunction

    function automatic longint unsigned sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic longint unsigned sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/div_clip_core.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// The dividend bits and the quotient share one shift register.
module div_clip_core
    import div_clip_pkg::*;
#(
    parameter int WIDTH_D = 16,
    parameter int WIDTH_O = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH_D:0]   rem_init,
    input  logic [WIDTH_O-1:0] dvd_init,
    input  logic [WIDTH_D-1:0] dsr,
    output logic               last,
    output logic [WIDTH_O-1:0] quo_next
);
    localparam int RW    = WIDTH_D + 1;
    localparam int CNT_W = cnt_width(WIDTH_O);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH_O - 1);

    logic [RW-1:0]      rem_reg;
    logic [RW-1:0]      rem_next;
    logic [WIDTH_O-1:0] sh_reg;
    logic [WIDTH_D-1:0] dsr_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               busy_reg;
    logic [RW:0]        trial;
    logic [RW:0]        dsr_ext;
    logic               q_bit;

    assign trial    = {rem_reg, sh_reg[WIDTH_O-1]};
    assign dsr_ext  = (RW + 1)'(dsr_reg);
    assign q_bit    = (trial >= dsr_ext);
    assign rem_next = q_bit ? RW'(trial - dsr_ext) : RW'(trial);
    assign quo_next = {sh_reg[WIDTH_O-2:0], q_bit};
    // Combinational so the top can register the final result on the same edge.
    assign last     = busy_reg && (cnt_reg == LAST_CNT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rem_reg  <= '0;
            sh_reg   <= '0;
            dsr_reg  <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
        end else if (start) begin
            rem_reg  <= rem_init;
            sh_reg   <= dvd_init;
            dsr_reg  <= dsr;
            cnt_reg  <= '0;
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            rem_reg <= rem_next;
            sh_reg  <= quo_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (last)
                busy_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/div_clip.sv
// Signed fixed-point divider with saturation, O = clip(N / D), streaming
// valid/ready on both sides with a single division in flight.
module div_clip
    import div_clip_pkg::*;
#(
    parameter int WIDTH_N  = 16,
    parameter int BIN_PT_N = 14,
    parameter int WIDTH_D  = 16,
    parameter int BIN_PT_D = 14,
    parameter int WIDTH_O  = 16,
    parameter int BIN_PT_O = 12
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH_N-1:0] in_tdata_n,
    input  logic [WIDTH_D-1:0] in_tdata_d,
    input  logic               in_tvalid,
    output logic               in_tready,
    output logic [WIDTH_O-1:0] out_tdata,
    output logic               out_clip,
    output logic               out_dbz,
    output logic               out_tvalid,
    input  logic               out_tready
);
    localparam int S      = shift_amt(BIN_PT_N, BIN_PT_D, BIN_PT_O);
    localparam int SU     = (S < 0) ? 0 : S;
    localparam int MW     = WIDTH_N + SU + WIDTH_O;
    localparam int RFW    = WIDTH_N + SU;
    localparam int RW     = WIDTH_D + 1;
    localparam int CMP_W  = RFW + RW;
    localparam logic [WIDTH_O-1:0] MAX_O = WIDTH_O'(sat_max(WIDTH_O));
    localparam logic [WIDTH_O-1:0] MIN_O = WIDTH_O'(sat_min(WIDTH_O));

    if (S < 0) begin : g_bad_shift
        $error("div_clip: BIN_PT_O - BIN_PT_N + BIN_PT_D must be non-negative");
    end

    state_t             state_reg;
    logic [WIDTH_N-1:0] n_reg;
    logic [WIDTH_D-1:0] d_reg;
    logic               sign_reg;
    logic               n_neg_reg;
    logic               ovf_reg;
    logic               dbz_reg;

    logic [WIDTH_N-1:0] n_mag;
    logic [WIDTH_D-1:0] d_mag;
    logic [MW-1:0]      m;
    logic [RFW-1:0]     r_full;
    logic [CMP_W-1:0]   r_cmp;
    logic [CMP_W-1:0]   d_cmp;
    logic               core_last;
    logic [WIDTH_O-1:0] core_quo;
    logic [WIDTH_O-1:0] res_next;
    logic               clip_next;

    // Negating the most negative value wraps to itself, which is the right unsigned magnitude.
    assign n_mag  = n_reg[WIDTH_N-1] ? -n_reg : n_reg;
    assign d_mag  = d_reg[WIDTH_D-1] ? -d_reg : d_reg;
    assign m      = MW'(n_mag) << SU;
    assign r_full = m[MW-1:WIDTH_O];
    assign r_cmp  = CMP_W'(r_full);
    assign d_cmp  = CMP_W'(d_mag);

    assign in_tready  = (state_reg == IDLE);
    assign out_tvalid = (state_reg == DONE);

    div_clip_core #(
        .WIDTH_D (WIDTH_D),
        .WIDTH_O (WIDTH_O)
    ) u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (state_reg == PREP),
        .rem_init (RW'(r_full)),
        .dvd_init (m[WIDTH_O-1:0]),
        .dsr      (d_mag),
        .last     (core_last),
        .quo_next (core_quo)
    );

    // A negative quotient of magnitude exactly 2^(WIDTH_O-1) is MIN and fits without clipping.
    always_comb begin
        res_next  = core_quo;
        clip_next = 1'b0;
        if (dbz_reg) begin
            res_next  = n_neg_reg ? MIN_O : MAX_O;
            clip_next = 1'b1;
        end else if (!sign_reg) begin
            if (ovf_reg || core_quo > MAX_O) begin
                res_next  = MAX_O;
                clip_next = 1'b1;
            end
        end else begin
            if (ovf_reg || core_quo > MIN_O) begin
                res_next  = MIN_O;
                clip_next = 1'b1;
            end else begin
                res_next = -core_quo;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            d_reg     <= '0;
            sign_reg  <= 1'b0;
            n_neg_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            dbz_reg   <= 1'b0;
            out_tdata <= '0;
            out_clip  <= 1'b0;
            out_dbz   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_tvalid) begin
                        n_reg     <= in_tdata_n;
                        d_reg     <= in_tdata_d;
                        state_reg <= PREP;
                    end
                end
                PREP: begin
                    sign_reg  <= n_reg[WIDTH_N-1] ^ d_reg[WIDTH_D-1];
                    n_neg_reg <= n_reg[WIDTH_N-1];
                    ovf_reg   <= (r_cmp >= d_cmp);
                    dbz_reg   <= (d_reg == '0);
                    state_reg <= CALC;
                end
                CALC: begin
                    if (core_last) begin
                        out_tdata <= res_next;
                        out_clip  <= clip_next;
                        out_dbz   <= dbz_reg;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_tready)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_clip.sv
// Scoreboard bench for div_clip: the driver queues expected results, a
// negedge monitor compares whatever the DUT presents and checks latency.
`timescale 1ns/1ps
module tb_div_clip;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in_tdata_n = '0;
    logic [15:0] in_tdata_d = '0;
    logic        in_tvalid = 1'b0;
    logic        in_tready;
    logic [15:0] out_tdata;
    logic        out_clip;
    logic        out_dbz;
    logic        out_tvalid;
    logic        out_tready = 1'b1;

    typedef struct packed {
        logic [15:0] n;
        logic [15:0] d;
        logic [15:0] data;
        logic        clip;
        logic        dbz;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   prev_v = 1'b0;

    div_clip dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_tdata_n (in_tdata_n),
        .in_tdata_d (in_tdata_d),
        .in_tvalid  (in_tvalid),
        .in_tready  (in_tready),
        .out_tdata  (out_tdata),
        .out_clip   (out_clip),
        .out_dbz    (out_dbz),
        .out_tvalid (out_tvalid),
        .out_tready (out_tready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency on the rising edge of out_tvalid, data every cycle it is held.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_v = 1'b0;
        end else begin
            if (in_tvalid && in_tready)
                acc_q.push_back(cyc);
            if (out_tvalid && !prev_v) begin
                if (acc_q.size() == 0)
                    check("valid_without_accept", out_tvalid, 1'b0);
                else
                    check("latency", cyc - acc_q.pop_front(), 18);
            end
            if (out_tvalid) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", out_tvalid, 1'b0);
                end else begin
                    check("out_tdata", out_tdata, sb[0].data);
                    check("out_clip", out_clip, sb[0].clip);
                    check("out_dbz", out_dbz, sb[0].dbz);
                    if (out_tready) begin
                        $display("xfer n=0x%04h d=0x%04h -> q=0x%04h clip=%0b dbz=%0b",
                                 sb[0].n, sb[0].d, out_tdata, out_clip, out_dbz);
                        void'(sb.pop_front());
                    end
                end
            end
            prev_v = out_tvalid;
        end
    end

    task automatic wait_ready();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (in_tready) ok = 1'b1;
        end
        if (!ok) check("accept_timeout", in_tready, 1'b1);
    endtask

    task automatic send(input logic [15:0] n, input logic [15:0] d,
                        input logic [15:0] data, input logic clip, input logic dbz);
        exp_t e;
        e = '{n: n, d: d, data: data, clip: clip, dbz: dbz};
        sb.push_back(e);
        @(posedge clk); #1;
        in_tdata_n = n;
        in_tdata_d = d;
        in_tvalid  = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_tvalid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++)
            @(negedge clk);
        check("drain", sb.size(), 0);
    endtask

    task automatic wait_out_valid();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (out_tvalid) ok = 1'b1;
        end
        if (!ok) check("result_timeout", out_tvalid, 1'b1);
    endtask

    // Hand-derived in Q2.14 / Q2.14 -> Q4.12; 0x0800 is 0.125, so -1.0/0.125 is exactly MIN.
    localparam int NV = 14;
    logic [15:0] tn [NV] = '{16'h2000, 16'hE000, 16'hFFFF, 16'h4000, 16'hC000, 16'hC000, 16'hC000,
                             16'h4000, 16'h1000, 16'h8000, 16'h0000, 16'h2000, 16'h0800, 16'h8000};
    logic [15:0] td [NV] = '{16'h1000, 16'h1000, 16'h3000, 16'h0400, 16'h0800, 16'h0200, 16'h0100,
                             16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'hF000, 16'h6000, 16'hC000};
    logic [15:0] tq [NV] = '{16'h2000, 16'hE000, 16'h0000, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000,
                             16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF, 16'hE000, 16'h0155, 16'h2000};
    logic        tc [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                             1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        tz [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        exp_t e;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_tvalid", out_tvalid, 1'b0);
        check("rst_out_tdata", out_tdata, 16'h0000);
        check("rst_out_clip", out_clip, 1'b0);
        check("rst_out_dbz", out_dbz, 1'b0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("idle_in_tready", in_tready, 1'b1);

        for (int i = 0; i < NV; i++)
            send(tn[i], td[i], tq[i], tc[i], tz[i]);
        drain();

        // Backpressure: hold the result while a second operand waits.
        @(posedge clk); #1;
        out_tready = 1'b0;
        send(16'h2000, 16'h1000, 16'h2000, 1'b0, 1'b0);
        e = '{n: 16'h4000, d: 16'h0800, data: 16'h7FFF, clip: 1'b1, dbz: 1'b0};
        sb.push_back(e);
        in_tdata_n = 16'h4000;
        in_tdata_d = 16'h0800;
        in_tvalid  = 1'b1;
        wait_out_valid();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_tready", in_tready, 1'b0);
            check("bp_out_tvalid", out_tvalid, 1'b1);
        end
        @(posedge clk); #1;
        out_tready = 1'b1;
        @(negedge clk);
        check("handshake_in_tready", in_tready, 1'b0);
        @(negedge clk);
        check("idle_after_handshake", in_tready, 1'b1);
        @(posedge clk); #1;
        in_tvalid = 1'b0;
        drain();

        // Asynchronous reset while a clipped result is held in DONE.
        @(posedge clk); #1;
        out_tready = 1'b0;
        send(16'h4000, 16'h0400, 16'h7FFF, 1'b1, 1'b0);
        wait_out_valid();
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_out_tvalid", out_tvalid, 1'b0);
        check("async_rst_out_tdata", out_tdata, 16'h0000);
        check("async_rst_out_clip", out_clip, 1'b0);
        sb.delete();
        acc_q.delete();
        @(negedge clk); #2;
        reset_n = 1'b1;
        out_tready = 1'b1;

        // Reset in the middle of CALC abandons the division.
        @(posedge clk); #1;
        in_tdata_n = 16'h2000;
        in_tdata_d = 16'h1000;
        in_tvalid  = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        in_tvalid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        check("calc_in_tready", in_tready, 1'b0);
        reset_n = 1'b0;
        #1;
        check("calc_rst_out_tvalid", out_tvalid, 1'b0);
        check("calc_rst_out_tdata", out_tdata, 16'h0000);
        check("calc_rst_in_tready", in_tready, 1'b1);
        acc_q.delete();
        @(negedge clk); #2;
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        send(16'h2000, 16'h1000, 16'h2000, 1'b0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
